rom_sequencer: RTL and testbench



---
 rtl/rom_seq_pkg.sv | 22 ++
 rtl/rom_sequencer.sv | 140 ++++++++++++++
 tb/tb_rom_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rom_seq_pkg.sv
// Shared definitions for the control-ROM sequencer: state encoding, default
// widths and the bit positions of the fields inside one control word.
package rom_seq_pkg;

  // Default ROM geometry: 8 addresses of 4-bit control words.
  localparam int SEQ_ADDR_W = 3;
  localparam int SEQ_CTRL_W = 4;

  // Control word layout: {alu_sel[1:0], mux_sel, load}.
  localparam int ALU_SEL_MSB = 3;
  localparam int ALU_SEL_LSB = 2;
  localparam int MUX_SEL_BIT = 1;
  localparam int LOAD_BIT    = 0;

  // Sequencer states. Everything except IDLE counts as busy.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage : rom_seq_pkg

// File: rtl/rom_sequencer.sv
// Control-ROM reader: on start, walks a program counter through ROM
// addresses 0..LAST_ADDR, registers each returned control word and drives
// alu_sel / mux_sel / load to the datapath with a start/busy/done handshake.
//
// Optional build macro ROM_SEQUENCER_LOOP_EN adds a 'loop' input. When it is
// high as the last word is fetched, the program restarts at address 0 without
// a bubble instead of passing through DONE.
//
// LAST_ADDR must be less than 2**ADDR_W; the pc never counts past it.
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W    = SEQ_ADDR_W,
  parameter int CTRL_W    = SEQ_CTRL_W,
  parameter int LAST_ADDR = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
`ifdef ROM_SEQUENCER_LOOP_EN
  input  logic              loop,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CTRL_W-1:0] rom_data,
  output logic [1:0]        alu_sel,
  output logic              mux_sel,
  output logic              load,
  output logic              busy,
  output logic              done
);

  // Final pc value, truncated to the counter width.
  localparam logic [ADDR_W-1:0] LAST_PC = LAST_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic              valid_q, valid_d;
  logic              done_q,  done_d;

  // pc at the last address: the word being fetched now ends a pass.
  logic              at_last;
  // Loop request, forced low when the loop feature is not built in.
  logic              loop_req;

  assign at_last = (pc_q == LAST_PC);

`ifdef ROM_SEQUENCER_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  // State register: reset wins over start and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: stall freezes every register in RUN and DONE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        // ctrl_q is left alone so alu_sel/mux_sel keep their last value.
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (start) begin
          pc_d    = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (!stall) begin
          ctrl_d  = rom_data;
          valid_d = 1'b1;
          if (at_last) begin
            // The word captured now is the last of this pass.
            done_d = 1'b1;
            if (loop_req) begin
              pc_d = '0;
            end else begin
              state_d = DONE;
            end
          end else begin
            pc_d   = pc_q + PC_ONE;
            done_d = 1'b0;
          end
        end
      end

      DONE: begin
        if (!stall) begin
          state_d = IDLE;
          valid_d = 1'b0;
          done_d  = 1'b0;
          pc_d    = '0;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b0;
        pc_d    = '0;
      end
    endcase
  end

  // Datapath-facing outputs. load is masked by stall so a frozen cycle never
  // loads the same word twice; the word loads on its last presented cycle.
  always_comb begin
    rom_addr = pc_q;
    alu_sel  = ctrl_q[ALU_SEL_MSB:ALU_SEL_LSB];
    mux_sel  = ctrl_q[MUX_SEL_BIT];
    load     = ctrl_q[LOAD_BIT] & valid_q & ~stall;
    busy     = (state_q != IDLE);
    done     = done_q;
  end

endmodule : rom_sequencer

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer. A small table of per-cycle vectors holds
// the inputs for each cycle and the hand-derived outputs expected during it.
// The standard program ROM is modelled inline as the rom_data source.
module tb_rom_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stall;
`ifdef ROM_SEQUENCER_LOOP_EN
  logic       loop;
`endif
  logic [2:0] rom_addr;
  logic [3:0] rom_data;
  logic [1:0] alu_sel;
  logic       mux_sel;
  logic       load;
  logic       busy;
  logic       done;

  int n_vec;
  int n_bad;

  // Standard program: words for addresses 0..6, address 7 unused.
  logic [3:0] rom_img [0:7];

  initial begin
    rom_img[0] = 4'h1; rom_img[1] = 4'h5; rom_img[2] = 4'h9; rom_img[3] = 4'hD;
    rom_img[4] = 4'hF; rom_img[5] = 4'hF; rom_img[6] = 4'hF; rom_img[7] = 4'h0;
  end

  assign rom_data = rom_img[rom_addr];

  rom_sequencer #(
    .ADDR_W   (3),
    .CTRL_W   (4),
    .LAST_ADDR(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stall   (stall),
`ifdef ROM_SEQUENCER_LOOP_EN
    .loop    (loop),
`endif
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .alu_sel (alu_sel),
    .mux_sel (mux_sel),
    .load    (load),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       sl;
    logic       lp;
    logic       rs;
    logic [2:0] addr;
    logic [3:0] word;
    logic       bsy;
    logic       dn;
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Queue one cycle: inputs held during it and outputs expected during it.
  task automatic add(input string name, input logic st, input logic sl, input logic lp,
                     input logic rs, input logic [2:0] addr, input logic [3:0] word,
                     input logic bsy, input logic dn);
    vec_t v;
    v.name = name; v.st = st; v.sl = sl; v.lp = lp; v.rs = rs;
    v.addr = addr; v.word = word; v.bsy = bsy; v.dn = dn;
    vq.push_back(v);
  endtask

  // Standard 7-word program after the start cycle: C0..C8 (no stall).
  task automatic add_program(input string name, input logic [3:0] c0_word, input logic st);
    add({name, "_c0"}, st, 0, 0, 0, 3'd0, c0_word, 1, 0);
    add({name, "_c1"}, st, 0, 0, 0, 3'd1, 4'h1, 1, 0);
    add({name, "_c2"}, st, 0, 0, 0, 3'd2, 4'h5, 1, 0);
    add({name, "_c3"}, st, 0, 0, 0, 3'd3, 4'h9, 1, 0);
    add({name, "_c4"}, st, 0, 0, 0, 3'd4, 4'hD, 1, 0);
    add({name, "_c5"}, st, 0, 0, 0, 3'd5, 4'hF, 1, 0);
    add({name, "_c6"}, st, 0, 0, 0, 3'd6, 4'hF, 1, 0);
    add({name, "_c7"}, st, 0, 0, 0, 3'd6, 4'hF, 1, 1);
    add({name, "_c8"}, st, 0, 0, 0, 3'd0, 4'hE, 0, 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
`ifdef ROM_SEQUENCER_LOOP_EN
    loop  = 1'b0;
`endif

    // Idle after reset.
    for (int i = 0; i < 5; i++) add("idle", 0, 0, 0, 0, 3'd0, 4'h0, 0, 0);

    // Plain program; C0 still shows reset ctrl.
    add("p1_start", 1, 0, 0, 0, 3'd0, 4'h0, 0, 0);
    add_program("p1", 4'h0, 0);

    // Stall two cycles while pc=3: word 9 held with load masked, D once.
    add("st_start", 1, 0, 0, 0, 3'd0, 4'hE, 0, 0);
    add("st_c0",    0, 0, 0, 0, 3'd0, 4'hE, 1, 0);
    add("st_c1",    0, 0, 0, 0, 3'd1, 4'h1, 1, 0);
    add("st_c2",    0, 0, 0, 0, 3'd2, 4'h5, 1, 0);
    add("st_c3",    0, 1, 0, 0, 3'd3, 4'h8, 1, 0);
    add("st_c4",    0, 1, 0, 0, 3'd3, 4'h8, 1, 0);
    add("st_c5",    0, 0, 0, 0, 3'd3, 4'h9, 1, 0);
    add("st_c6",    0, 0, 0, 0, 3'd4, 4'hD, 1, 0);
    add("st_c7",    0, 0, 0, 0, 3'd5, 4'hF, 1, 0);
    add("st_c8",    0, 0, 0, 0, 3'd6, 4'hF, 1, 0);
    add("st_c9",    0, 0, 0, 0, 3'd6, 4'hF, 1, 1);
    add("st_c10",   0, 0, 0, 0, 3'd0, 4'hE, 0, 0);

    // start held high: ignored in RUN/DONE, restarts only from IDLE.
    add("hold_start", 1, 0, 0, 0, 3'd0, 4'hE, 0, 0);
    add_program("hold", 4'hE, 1);
    add("hold_c9",  1, 0, 0, 0, 3'd0, 4'hE, 1, 0);
    add("hold_c10", 1, 0, 0, 0, 3'd1, 4'h1, 1, 0);
    add("hold_c11", 1, 0, 0, 0, 3'd2, 4'h5, 1, 0);
    add("hold_c12", 1, 0, 0, 0, 3'd3, 4'h9, 1, 0);
    // Reset at pc=4 together with start: reset wins.
    add("rst_pc4",  1, 0, 0, 1, 3'd4, 4'hD, 1, 0);
    add("rst_after", 1, 0, 0, 0, 3'd0, 4'h0, 0, 0);
    add_program("fresh", 4'h0, 0);

`ifdef ROM_SEQUENCER_LOOP_EN
    // loop=1 on the first pass: address 0 follows address 6 with no bubble.
    add("lp_start", 1, 0, 1, 0, 3'd0, 4'hE, 0, 0);
    add("lp_c0",    0, 0, 1, 0, 3'd0, 4'hE, 1, 0);
    add("lp_c1",    0, 0, 1, 0, 3'd1, 4'h1, 1, 0);
    add("lp_c2",    0, 0, 1, 0, 3'd2, 4'h5, 1, 0);
    add("lp_c3",    0, 0, 1, 0, 3'd3, 4'h9, 1, 0);
    add("lp_c4",    0, 0, 1, 0, 3'd4, 4'hD, 1, 0);
    add("lp_c5",    0, 0, 1, 0, 3'd5, 4'hF, 1, 0);
    add("lp_c6",    0, 0, 1, 0, 3'd6, 4'hF, 1, 0);
    add("lp_c7",    0, 0, 0, 0, 3'd0, 4'hF, 1, 1);
    add("lp_c8",    0, 0, 0, 0, 3'd1, 4'h1, 1, 0);
    add("lp_c9",    0, 0, 0, 0, 3'd2, 4'h5, 1, 0);
    add("lp_c10",   0, 0, 0, 0, 3'd3, 4'h9, 1, 0);
    add("lp_c11",   0, 0, 0, 0, 3'd4, 4'hD, 1, 0);
    add("lp_c12",   0, 0, 0, 0, 3'd5, 4'hF, 1, 0);
    add("lp_c13",   0, 0, 0, 0, 3'd6, 4'hF, 1, 0);
    add("lp_c14",   0, 0, 0, 0, 3'd6, 4'hF, 1, 1);
    add("lp_c15",   0, 0, 0, 0, 3'd0, 4'hE, 0, 0);
`endif

    // Apply reset for two edges, then release at posedge+1.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vq[i]) begin
      start = vq[i].st;
      stall = vq[i].sl;
      rst   = vq[i].rs;
`ifdef ROM_SEQUENCER_LOOP_EN
      loop  = vq[i].lp;
`endif
      #1;
      check({vq[i].name, "_addr"}, {5'd0, rom_addr}, {5'd0, vq[i].addr});
      check({vq[i].name, "_word"}, {4'd0, alu_sel, mux_sel, load}, {4'd0, vq[i].word});
      check({vq[i].name, "_busy"}, {7'd0, busy}, {7'd0, vq[i].bsy});
      check({vq[i].name, "_done"}, {7'd0, done}, {7'd0, vq[i].dn});
      $display("cyc %0d %s: start=%b stall=%b rst=%b addr=%0d word=%h busy=%b done=%b",
               i, vq[i].name, start, stall, rst, rom_addr,
               {alu_sel, mux_sel, load}, busy, done);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_rom_sequencer
